// File: rtl/parser_lit_arbiter.sv
// parser_lit_arbiter
//   Round-robin write arbiter that lets several literal-parser lanes share one
//   literal FIFO. One lane is picked per beat (or held for a whole token when
//   locking is compiled in), the chosen beat passes through a single registered
//   stage into the FIFO write port, and acceptance is throttled by the FIFO's
//   prog_full / full flags.
//
//   Optional feature macro: PARSER_LIT_ARB_LOCK_EN
//     defined   : a lane that starts a multi-beat token keeps the grant until
//                 the beat carrying req_last is accepted.
//     undefined : req_last is ignored and round-robin runs per beat.
module parser_lit_arbiter #(
  parameter int WIDTH = 85,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_prog_full,
  output logic [31:0]           beat_cnt
);

  // Index width for the round-robin pointer; kept at least one bit wide.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Registered state
  state_t           state_r;
  logic [IW-1:0]    last_idx_r;
  logic [WIDTH-1:0] fifo_din_r;
  logic             fifo_wr_en_r;
  logic [31:0]      beat_cnt_r;

  // Combinational arbitration signals
  logic [IW-1:0]    cand_s;
  logic [IW-1:0]    search_idx_s;
  logic             search_hit_s;
  logic [IW-1:0]    gnt_idx_s;
  logic             gnt_vld_s;
  logic [NREQ-1:0]  grant_s;
  logic [NREQ-1:0]  ready_s;
  logic [WIDTH-1:0] gnt_data_s;
  logic             open_s;
  logic             accept_s;

`ifdef PARSER_LIT_ARB_LOCK_EN
  logic             accept_last_s;
`else
  // req_last carries no meaning without token locking.
  logic             unused_last_s;
  assign unused_last_s = ^req_last;
`endif

  // Round-robin search: first valid lane starting just after the last winner.
  always_comb begin
    search_hit_s = 1'b0;
    search_idx_s = '0;
    cand_s       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_idx_r) + k) % NREQ);
      if (!search_hit_s && req_valid[cand_s]) begin
        search_hit_s = 1'b1;
        search_idx_s = cand_s;
      end else begin
        search_hit_s = search_hit_s;
        search_idx_s = search_idx_s;
      end
    end
  end

  // Grant source: the search result in ARB, the locked lane in LOCK. The
  // locked lane is always the most recently accepted one, so last_idx_r
  // doubles as the lock pointer and no separate register is needed.
  always_comb begin
    if (state_r == ST_LOCK) begin
      gnt_vld_s = 1'b1;
      gnt_idx_s = last_idx_r;
    end else begin
      gnt_vld_s = search_hit_s;
      gnt_idx_s = search_idx_s;
    end
  end

  // One-hot grant decode and AND-OR data mux of the granted lane.
  always_comb begin
    grant_s    = '0;
    gnt_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_s[i] = gnt_vld_s && (gnt_idx_s == IW'(i));
      gnt_data_s = gnt_data_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // The FIFO is open only while neither prog_full nor the full guard is set;
  // prog_full at 3 of 8 leaves room for the single registered beat in flight.
  assign open_s   = !fifo_prog_full && !fifo_full;
  assign ready_s  = grant_s & {NREQ{open_s}};
  assign accept_s = |(req_valid & ready_s);

`ifdef PARSER_LIT_ARB_LOCK_EN
  assign accept_last_s = |(req_last & grant_s);
`endif

  // Write stage: register the accepted beat, remember the winner, count beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_din_r   <= '0;
      fifo_wr_en_r <= 1'b0;
      beat_cnt_r   <= 32'd0;
      last_idx_r   <= IW'(NREQ - 1);
    end else if (accept_s) begin
      fifo_din_r   <= gnt_data_s;
      fifo_wr_en_r <= 1'b1;
      beat_cnt_r   <= beat_cnt_r + 32'd1;
      last_idx_r   <= gnt_idx_s;
    end else begin
      fifo_wr_en_r <= 1'b0;
    end
  end

  // Arbitration FSM: enter LOCK on a non-last beat, leave on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ARB;
    end else begin
`ifdef PARSER_LIT_ARB_LOCK_EN
      case (state_r)
        ST_ARB: begin
          if (accept_s && !accept_last_s) begin
            state_r <= ST_LOCK;
          end else begin
            state_r <= ST_ARB;
          end
        end
        ST_LOCK: begin
          if (accept_s && accept_last_s) begin
            state_r <= ST_ARB;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: state_r <= ST_ARB;
      endcase
`else
      state_r <= ST_ARB;
`endif
    end
  end

  assign grant      = grant_s;
  assign req_ready  = ready_s;
  assign fifo_din   = fifo_din_r;
  assign fifo_wr_en = fifo_wr_en_r;
  assign beat_cnt   = beat_cnt_r;

endmodule

// File: tb/tb_parser_lit_arbiter.sv
// tb_parser_lit_arbiter
//   Directed bench for parser_lit_arbiter: reset values, single-lane latency,
//   round-robin order, sole requester, prog_full / full throttling, token
//   behaviour with and without PARSER_LIT_ARB_LOCK_EN, and reset mid-token.
module tb_parser_lit_arbiter;

  localparam int WIDTH = 85;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  fifo_prog_full;
  logic [31:0]           beat_cnt;

  int passed = 0;
  int total  = 0;

  parser_lit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .grant          (grant),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .beat_cnt       (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid      = '0;
    req_last       = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
    req_valid[i]                = v;
    req_last[i]                 = l;
    req_data[i*WIDTH +: WIDTH]  = d;
  endtask

  task automatic all_lanes_valid();
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 1'b1, WIDTH'(32'h100 + i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One lane-0 single-beat token so the pointer sits on lane 0.
  task automatic prime_lane0();
    @(negedge clk);
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, WIDTH'(32'hAA));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== '0) $display("FAIL reset_din: got %h expected 0", fifo_din); else passed++;
    total++; if (beat_cnt !== 32'd0) $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); else passed++;
    total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_lane();
    do_reset();
    @(negedge clk);
    set_lane(2, 1'b1, 1'b1, WIDTH'(32'h1A));
    #1;
    total++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", grant); else passed++;
    total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", req_ready); else passed++;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL single_wr_en_early: got %b expected 0", fifo_wr_en); else passed++;
    @(posedge clk);
    #1;
    total++; if (fifo_wr_en !== 1'b1) $display("FAIL single_wr_en: got %b expected 1", fifo_wr_en); else passed++;
    total++; if (fifo_din !== WIDTH'(32'h1A)) $display("FAIL single_din: got %h expected 1a", fifo_din); else passed++;
    total++; if (beat_cnt !== 32'd1) $display("FAIL single_beat_cnt: got %0d expected 1", beat_cnt); else passed++;
    @(negedge clk);
    clear_inputs();
    #1;
    total++; if (grant !== 4'b0000) $display("FAIL single_idle_grant: got %b expected 0000", grant); else passed++;
    @(posedge clk);
    #1;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL single_idle_wr_en: got %b expected 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== WIDTH'(32'h1A)) $display("FAIL single_din_hold: got %h expected 1a", fifo_din); else passed++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_g;
    logic [WIDTH-1:0] exp_d;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      all_lanes_valid();
      exp_g = 4'b0001 << (c % 4);
      exp_d = WIDTH'(32'h100 + (c % 4));
      #1;
      total++; if (grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b expected %b", c, grant, exp_g); else passed++;
      @(posedge clk);
      #1;
      total++; if (fifo_din !== exp_d) $display("FAIL rr_din[%0d]: got %h expected %h", c, fifo_din, exp_d); else passed++;
    end
    total++; if (beat_cnt !== 32'd8) $display("FAIL rr_beat_cnt: got %0d expected 8", beat_cnt); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_sole_requester();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_lane(3, 1'b1, 1'b1, WIDTH'(32'h300 + c));
      #1;
      total++; if (grant !== 4'b1000) $display("FAIL sole_grant[%0d]: got %b expected 1000", c, grant); else passed++;
      @(posedge clk);
    end
    #1;
    total++; if (beat_cnt !== 32'd3) $display("FAIL sole_beat_cnt: got %0d expected 3", beat_cnt); else passed++;
    total++; if (fifo_din !== WIDTH'(32'h302)) $display("FAIL sole_din: got %h expected 302", fifo_din); else passed++;
  endtask

  task automatic test_throttle();
    do_reset();
    // Cycle 0: open, lane 0 accepted.
    @(negedge clk);
    all_lanes_valid();
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL thr_ready_open: got %b expected 0001", req_ready); else passed++;
    @(posedge clk);
    // Cycles 1..5: prog_full held high.
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      fifo_prog_full = 1'b1;
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL thr_ready[%0d]: got %b expected 0000", c, req_ready); else passed++;
      if (c == 1) begin
        total++; if (fifo_wr_en !== 1'b1) $display("FAIL thr_inflight_wr_en: got %b expected 1", fifo_wr_en); else passed++;
      end
      @(posedge clk);
      #1;
      total++; if (fifo_wr_en !== 1'b0) $display("FAIL thr_wr_en[%0d]: got %b expected 0", c, fifo_wr_en); else passed++;
    end
    // Release: lane 1 is next and exactly one beat goes through.
    @(negedge clk);
    fifo_prog_full = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL thr_ready_release: got %b expected 0010", req_ready); else passed++;
    @(posedge clk);
    #1;
    total++; if (fifo_din !== WIDTH'(32'h101)) $display("FAIL thr_din_release: got %h expected 101", fifo_din); else passed++;
    total++; if (beat_cnt !== 32'd2) $display("FAIL thr_beat_cnt: got %0d expected 2", beat_cnt); else passed++;
    // Full alone also blocks acceptance.
    @(negedge clk);
    fifo_full = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL full_ready: got %b expected 0000", req_ready); else passed++;
    @(posedge clk);
    #1;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en: got %b expected 0", fifo_wr_en); else passed++;
    total++; if (beat_cnt !== 32'd2) $display("FAIL full_beat_cnt: got %0d expected 2", beat_cnt); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  // Lane 1 sends a 3-beat token while lane 0 keeps a single-beat token valid.
  task automatic test_token();
    logic [NREQ-1:0]  exp_g [4];
    logic [WIDTH-1:0] exp_d;
    int beat;
`ifdef PARSER_LIT_ARB_LOCK_EN
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
    exp_g = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    do_reset();
    prime_lane0();
    beat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_lane(0, 1'b1, 1'b1, WIDTH'(32'hAA));
      set_lane(1, (beat < 3), (beat == 2), WIDTH'(32'h200 + beat));
      exp_d = (exp_g[c] == 4'b0010) ? WIDTH'(32'h200 + beat) : WIDTH'(32'hAA);
      #1;
      total++; if (grant !== exp_g[c]) $display("FAIL token_grant[%0d]: got %b expected %b", c, grant, exp_g[c]); else passed++;
      @(posedge clk);
      #1;
      total++; if (fifo_din !== exp_d) $display("FAIL token_din[%0d]: got %h expected %h", c, fifo_din, exp_d); else passed++;
      if (exp_g[c] == 4'b0010) beat++;
    end
    total++; if (beat_cnt !== 32'd5) $display("FAIL token_beat_cnt: got %0d expected 5", beat_cnt); else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef PARSER_LIT_ARB_LOCK_EN
  // Locked lane drops valid for two cycles; the grant must not move.
  task automatic test_lock_stall();
    do_reset();
    prime_lane0();
    @(negedge clk);
    set_lane(0, 1'b1, 1'b1, WIDTH'(32'hAA));
    set_lane(1, 1'b1, 1'b0, WIDTH'(32'h300));
    #1;
    total++; if (grant !== 4'b0010) $display("FAIL stall_grant_start: got %b expected 0010", grant); else passed++;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_lane(1, 1'b0, 1'b0, WIDTH'(32'h0));
      #1;
      total++; if (grant !== 4'b0010) $display("FAIL stall_grant[%0d]: got %b expected 0010", c, grant); else passed++;
      @(posedge clk);
      #1;
      total++; if (fifo_wr_en !== 1'b0) $display("FAIL stall_wr_en[%0d]: got %b expected 0", c, fifo_wr_en); else passed++;
    end
    @(negedge clk);
    set_lane(1, 1'b1, 1'b1, WIDTH'(32'h301));
    #1;
    total++; if (grant !== 4'b0010) $display("FAIL stall_grant_end: got %b expected 0010", grant); else passed++;
    @(posedge clk);
    #1;
    total++; if (fifo_din !== WIDTH'(32'h301)) $display("FAIL stall_din_end: got %h expected 301", fifo_din); else passed++;
    @(negedge clk);
    set_lane(1, 1'b0, 1'b0, WIDTH'(32'h0));
    #1;
    total++; if (grant !== 4'b0001) $display("FAIL stall_grant_after: got %b expected 0001", grant); else passed++;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask
`endif

  task automatic test_reset_mid_token();
    do_reset();
    prime_lane0();
    @(negedge clk);
    set_lane(0, 1'b1, 1'b1, WIDTH'(32'h100));
    set_lane(1, 1'b1, 1'b0, WIDTH'(32'h101));
    @(posedge clk);
    #1;
    total++; if (fifo_wr_en !== 1'b1) $display("FAIL rstmid_pending: got %b expected 1", fifo_wr_en); else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b expected 0", fifo_wr_en); else passed++;
    total++; if (beat_cnt !== 32'd0) $display("FAIL rstmid_beat_cnt: got %0d expected 0", beat_cnt); else passed++;
    total++; if (grant !== 4'b0001) $display("FAIL rstmid_grant_in_reset: got %b expected 0001", grant); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    all_lanes_valid();
    #1;
    total++; if (grant !== 4'b0001) $display("FAIL rstmid_grant: got %b expected 0001", grant); else passed++;
    @(posedge clk);
    #1;
    total++; if (beat_cnt !== 32'd1) $display("FAIL rstmid_beat_cnt_after: got %0d expected 1", beat_cnt); else passed++;
    @(negedge clk);
    #1;
    total++; if (grant !== 4'b0010) $display("FAIL rstmid_grant_next: got %b expected 0010", grant); else passed++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_sole_requester();
    test_throttle();
    test_token();
`ifdef PARSER_LIT_ARB_LOCK_EN
    test_lock_stall();
`endif
    test_reset_mid_token();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
